mdll_loop_ctrl: RTL and testbench

Digital loop controller for the MDLL. Consumes the `lead`/`lag` pulses from the MDLL phase detector, synchronises and majority-filters them, and steps the delay-line control word of the digitally controlled delay line. Tracks dither around the lock point and drives a `locked` indication. Sits between the phase detector and the delay-line code input, clocked by the reference clock.

---
 rtl/mdll_pkg.sv | 34 +++
 rtl/mdll_loop_ctrl_if.sv | 26 ++
 rtl/mdll_sync2.sv | 23 ++
 rtl/mdll_loop_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mdll_loop_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdll_pkg.sv
// Shared types and default constants for the MDLL digital loop controller.
// Vote encoding doubles as the step-direction record kept by the tracker.
package mdll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    VOTE_NONE = 2'b00,
    VOTE_UP   = 2'b01,
    VOTE_DN   = 2'b10
  } vote_e;

  localparam int CODE_W_DEF    = 6;
  localparam int CODE_INIT_DEF = 32;
  localparam int FILT_TH_DEF   = 8;
  localparam int ACC_W_DEF     = 5;
  localparam int LOCK_REV_DEF  = 4;

  // Both-high is the PD self-reset transient, so it votes like neither.
  function automatic vote_e vote_of(input logic up, input logic dn);
    vote_e v;
    case ({up, dn})
      2'b10:   v = VOTE_UP;
      2'b01:   v = VOTE_DN;
      default: v = VOTE_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mdll_loop_ctrl_if.sv
// Phase-detector inputs and delay-line control outputs of the loop controller.
// The controller takes the slave view; the driving environment takes the master view.
interface mdll_loop_ctrl_if
  import mdll_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
);
  logic              lead;
  logic              lag;
  logic              en;
  logic [CODE_W-1:0] dly_code;
  logic              update;
  logic              locked;
  logic              sat_hi;
  logic              sat_lo;

  modport master (
    output lead, lag, en,
    input  dly_code, update, locked, sat_hi, sat_lo
  );

  modport slave (
    input  lead, lag, en,
    output dly_code, update, locked, sat_hi, sat_lo
  );
endinterface

// File: rtl/mdll_sync2.sv
// Two-flop synchroniser for the asynchronous phase-detector flags.
module mdll_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  // Metastability chain; both stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/mdll_loop_ctrl.sv
// MDLL loop controller: synchronises lead/lag, majority-filters the votes into
// code steps, tracks direction reversals for lock, and drives the delay code.
module mdll_loop_ctrl
  import mdll_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int CODE_INIT = CODE_INIT_DEF,
  parameter int FILT_TH   = FILT_TH_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int LOCK_REV  = LOCK_REV_DEF
) (
  input  logic           clk_in,
  input  logic           rst,
  mdll_loop_ctrl_if.slave bus
);
  localparam int REV_W = $clog2(LOCK_REV + 1);
  localparam logic [REV_W-1:0]        REV_MAX  = REV_W'(LOCK_REV);
  localparam logic [CODE_W-1:0]       CODE_MAX = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0]       CODE_RST = CODE_W'(CODE_INIT);
  localparam logic signed [ACC_W:0]   TH_POS   = (ACC_W + 1)'(FILT_TH);
  localparam logic signed [ACC_W:0]   TH_NEG   = -TH_POS;
  localparam logic signed [ACC_W:0]   INC_UP   = (ACC_W + 1)'(1);
  localparam logic signed [ACC_W:0]   INC_DN   = -INC_UP;

  logic lead_s;
  logic lag_s;

  mdll_sync2 u_sync_lead (.clk(clk_in), .rst(rst), .d(bus.lead), .q(lead_s));
  mdll_sync2 u_sync_lag  (.clk(clk_in), .rst(rst), .d(bus.lag),  .q(lag_s));

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CODE_W-1:0]       code_q, code_d;
  logic [REV_W-1:0]        rev_q, rev_d;
  vote_e                   last_dir_q, last_dir_d;
  logic                    update_q, update_d;
  logic                    locked_q, locked_d;

  vote_e                   vote;
  logic signed [ACC_W:0]   inc;
  logic signed [ACC_W:0]   acc_sum;
  logic                    step;
  vote_e                   step_dir;

  // Vote and accumulate; a dropped enable suppresses the vote, so it wins over a crossing.
  always_comb begin
    vote     = VOTE_NONE;
    inc      = '0;
    step     = 1'b0;
    step_dir = VOTE_NONE;
    if (bus.en && (state_q != IDLE)) begin
      vote = vote_of(lead_s, lag_s);
    end else begin
      vote = VOTE_NONE;
    end
    case (vote)
      VOTE_UP: inc = INC_UP;
      VOTE_DN: inc = INC_DN;
      default: inc = '0;
    endcase
    acc_sum = {acc_q[ACC_W-1], acc_q} + inc;
    if (acc_sum >= TH_POS) begin
      step     = 1'b1;
      step_dir = VOTE_UP;
    end else if (acc_sum <= TH_NEG) begin
      step     = 1'b1;
      step_dir = VOTE_DN;
    end else begin
      step     = 1'b0;
      step_dir = VOTE_NONE;
    end
  end

  // FSM, code register and direction tracker next-state.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    code_d     = code_q;
    rev_d      = rev_q;
    last_dir_d = last_dir_q;
    update_d   = 1'b0;
    locked_d   = locked_q;
    case (state_q)
      IDLE: begin
        acc_d      = '0;
        rev_d      = '0;
        last_dir_d = VOTE_NONE;
        locked_d   = 1'b0;
        if (bus.en) begin
          state_d = ACQ;
        end else begin
          state_d = IDLE;
        end
      end
      ACQ, LOCK: begin
        if (!bus.en) begin
          state_d    = IDLE;
          acc_d      = '0;
          rev_d      = '0;
          last_dir_d = VOTE_NONE;
          locked_d   = 1'b0;
        end else if (step) begin
          acc_d      = '0;
          last_dir_d = step_dir;
          // A step at a rail leaves the code alone but still feeds the tracker.
          if ((step_dir == VOTE_UP) && (code_q != CODE_MAX)) begin
            code_d   = code_q + CODE_W'(1);
            update_d = 1'b1;
          end else if ((step_dir == VOTE_DN) && (code_q != '0)) begin
            code_d   = code_q - CODE_W'(1);
            update_d = 1'b1;
          end else begin
            code_d   = code_q;
            update_d = 1'b0;
          end
          if (last_dir_q == VOTE_NONE) begin
            rev_d = rev_q;
          end else if (last_dir_q != step_dir) begin
            rev_d = (rev_q == REV_MAX) ? rev_q : rev_q + REV_W'(1);
          end else begin
            rev_d = '0;
          end
          if (state_q == ACQ) begin
            if (rev_d == REV_MAX) begin
              state_d  = LOCK;
              locked_d = 1'b1;
            end else begin
              state_d  = ACQ;
            end
          end else begin
            if (last_dir_q == step_dir) begin
              state_d  = ACQ;
              locked_d = 1'b0;
              rev_d    = '0;
            end else begin
              state_d  = LOCK;
            end
          end
        end else begin
          acc_d = acc_sum[ACC_W-1:0];
        end
      end
      default: begin
        state_d    = IDLE;
        acc_d      = '0;
        rev_d      = '0;
        last_dir_d = VOTE_NONE;
        locked_d   = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      code_q     <= CODE_RST;
      rev_q      <= '0;
      last_dir_q <= VOTE_NONE;
      update_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      code_q     <= code_d;
      rev_q      <= rev_d;
      last_dir_q <= last_dir_d;
      update_q   <= update_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.dly_code = code_q;
  assign bus.update   = update_q;
  assign bus.locked   = locked_q;
  assign bus.sat_hi   = (code_q == CODE_MAX);
  assign bus.sat_lo   = (code_q == '0);
endmodule

// File: tb/tb_mdll_loop_ctrl.sv
// Directed bench for mdll_loop_ctrl: expected code/update/locked triples are
// queued when stimulus is applied and popped when the DUT is sampled.
module tb_mdll_loop_ctrl;
  import mdll_pkg::*;

  typedef struct {
    string      tag;
    logic [5:0] code;
    logic       upd;
    logic       lck;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk_in = ~clk_in;

  mdll_loop_ctrl_if #(.CODE_W(6)) bus_if ();

  mdll_loop_ctrl #(
    .CODE_W(6), .CODE_INIT(32), .FILT_TH(8), .ACC_W(5), .LOCK_REV(4)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus_if.slave)
  );

  task automatic step_edges(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [5:0] code, input logic upd, input logic lck);
    exp_t e;
    e.tag = tag; e.code = code; e.upd = upd; e.lck = lck;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_code"},   32'(bus_if.dly_code), 32'(e.code));
      chk({e.tag, "_update"}, 32'(bus_if.update),   32'(e.upd));
      chk({e.tag, "_locked"}, 32'(bus_if.locked),   32'(e.lck));
    end
  endtask

  task automatic set_in(input logic l, input logic g, input logic e);
    bus_if.lead = l;
    bus_if.lag  = g;
    bus_if.en   = e;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step_edges(3);
    rst = 1'b0;
    step_edges(2);
  endtask

  initial begin
    // Reset state
    set_in(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step_edges(3);
    sb_push("rst", 6'd32, 1'b0, 1'b0);
    sb_check();
    chk("rst_sat_hi", 32'(bus_if.sat_hi), 32'd0);
    chk("rst_sat_lo", 32'(bus_if.sat_lo), 32'd0);
    rst = 1'b0;
    sb_push("idle_hold", 6'd32, 1'b0, 1'b0);
    step_edges(20);
    sb_check();
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Step latency with lead held
    set_in(1'b1, 1'b0, 1'b1);
    sb_push("lead_e3_acc", 6'd32, 1'b0, 1'b0);
    step_edges(3);
    sb_check();
    chk("lead_e3_acc", 32'($unsigned(dut.acc_q)), 32'd1);
    sb_push("lead_e9", 6'd32, 1'b0, 1'b0);
    step_edges(6);
    sb_check();
    sb_push("lead_e10", 6'd33, 1'b1, 1'b0);
    step_edges(1);
    sb_check();
    sb_push("lead_e11", 6'd33, 1'b0, 1'b0);
    step_edges(1);
    sb_check();
    sb_push("lead_e18", 6'd34, 1'b1, 1'b0);
    step_edges(7);
    sb_check();

    // Step latency with lag held
    do_reset();
    set_in(1'b0, 1'b1, 1'b1);
    sb_push("lag_e9", 6'd32, 1'b0, 1'b0);
    step_edges(9);
    sb_check();
    sb_push("lag_e10", 6'd31, 1'b1, 1'b0);
    step_edges(1);
    sb_check();

    // Both-high is ignored
    do_reset();
    set_in(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step_edges(1);
      chk("both_acc", 32'($unsigned(dut.acc_q)), 32'd0);
      chk("both_update", 32'(bus_if.update), 32'd0);
    end
    sb_push("both_end", 6'd32, 1'b0, 1'b0);
    sb_check();

    // Saturation high
    do_reset();
    set_in(1'b1, 1'b0, 1'b1);
    sb_push("sat_hi_62", 6'd62, 1'b1, 1'b0);
    step_edges(242);
    sb_check();
    sb_push("sat_hi_63", 6'd63, 1'b1, 1'b0);
    step_edges(8);
    sb_check();
    chk("sat_hi_flag", 32'(bus_if.sat_hi), 32'd1);
    chk("sat_hi_lo_flag", 32'(bus_if.sat_lo), 32'd0);
    for (int i = 0; i < 20; i++) begin
      sb_push("sat_hi_pinned", 6'd63, 1'b0, 1'b0);
      step_edges(1);
      sb_check();
    end

    // Saturation low
    do_reset();
    set_in(1'b0, 1'b1, 1'b1);
    sb_push("sat_lo_0", 6'd0, 1'b1, 1'b0);
    step_edges(258);
    sb_check();
    chk("sat_lo_flag", 32'(bus_if.sat_lo), 32'd1);
    for (int i = 0; i < 12; i++) begin
      sb_push("sat_lo_pinned", 6'd0, 1'b0, 1'b0);
      step_edges(1);
      sb_check();
    end

    // Lock acquire by alternating steps, then loss by holding lead
    do_reset();
    bus_if.en = 1'b1;
    for (int p = 0; p < 5; p++) begin
      bus_if.lead = (p % 2 == 0);
      bus_if.lag  = (p % 2 != 0);
      step_edges(8);
    end
    sb_push("alt_e40", 6'd32, 1'b0, 1'b0);
    sb_check();
    set_in(1'b0, 1'b1, 1'b1);
    sb_push("alt_e41", 6'd32, 1'b0, 1'b0);
    step_edges(1);
    sb_check();
    sb_push("lock_e42", 6'd33, 1'b1, 1'b1);
    step_edges(1);
    sb_check();
    chk("lock_state", 32'(dut.state_q), 32'(LOCK));
    step_edges(6);
    set_in(1'b1, 1'b0, 1'b1);
    sb_push("lock_dn_e50", 6'd32, 1'b1, 1'b1);
    step_edges(2);
    sb_check();
    sb_push("lock_up1_e58", 6'd33, 1'b1, 1'b1);
    step_edges(8);
    sb_check();
    sb_push("lock_e65", 6'd33, 1'b0, 1'b1);
    step_edges(7);
    sb_check();
    sb_push("unlock_e66", 6'd34, 1'b1, 1'b0);
    step_edges(1);
    sb_check();
    chk("unlock_state", 32'(dut.state_q), 32'(ACQ));

    // Asynchronous reset while locked at code 40
    do_reset();
    bus_if.en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      bus_if.lead = (p < 8) || (p == 9) || (p == 11);
      bus_if.lag  = !bus_if.lead;
      step_edges(8);
    end
    set_in(1'b0, 1'b0, 1'b1);
    sb_push("lock40", 6'd40, 1'b1, 1'b1);
    step_edges(2);
    sb_check();
    #2;
    rst = 1'b1;
    #1;
    sb_push("async_rst", 6'd32, 1'b0, 1'b0);
    sb_check();
    chk("async_rst_state", 32'(dut.state_q), 32'(IDLE));
    step_edges(2);
    rst = 1'b0;
    step_edges(2);

    // Enable dropped on the threshold edge
    do_reset();
    set_in(1'b1, 1'b0, 1'b1);
    step_edges(9);
    bus_if.en = 1'b0;
    sb_push("en_drop_e10", 6'd32, 1'b0, 1'b0);
    step_edges(1);
    sb_check();
    chk("en_drop_state", 32'(dut.state_q), 32'(IDLE));
    chk("en_drop_acc", 32'($unsigned(dut.acc_q)), 32'd0);
    sb_push("en_drop_hold", 6'd32, 1'b0, 1'b0);
    step_edges(10);
    sb_check();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
